// File: rtl/long_latency_scoreboard.sv
// Pending-write scoreboard for long-latency results (loads, mul/div) that cannot be
// bypassed from EX; raises the ID-stage stall on RAW/WAW hazards against them.
module long_latency_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       rs1_addr_id,
    input  logic [4:0]       rs2_addr_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       rd_addr_id,
    input  logic             id_reg_we,
    input  logic             id_long,
    input  logic             id_flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd_addr,
    output logic             stall,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             sb_err
);

    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [31:0] clr_mask_s;
    logic [31:0] set_mask_s;
    logic [31:0] eff_pending_s;
    logic        wb_hit_s;
    logic        wb_bad_s;
    logic        raw1_s;
    logic        raw2_s;
    logic        waw_s;
    logic        full_s;
    logic        accept_s;
    logic        ovf_s;

    // Hazard detection and issue acceptance; a same-cycle writeback releases its register.
    always_comb begin
        wb_hit_s      = wb_valid && (wb_rd_addr != 5'd0) && pending_q[wb_rd_addr];
        wb_bad_s      = wb_valid && (wb_rd_addr != 5'd0) && !pending_q[wb_rd_addr];
        clr_mask_s    = wb_hit_s ? (32'd1 << wb_rd_addr) : 32'd0;
        eff_pending_s = pending_q & ~clr_mask_s;
        raw1_s        = rs1_used && (rs1_addr_id != 5'd0) && eff_pending_s[rs1_addr_id];
        raw2_s        = rs2_used && (rs2_addr_id != 5'd0) && eff_pending_s[rs2_addr_id];
        waw_s         = id_reg_we && (rd_addr_id != 5'd0) && eff_pending_s[rd_addr_id];
        full_s        = id_long && id_reg_we && (rd_addr_id != 5'd0) &&
                        (cnt_q == CNT_W'(MAX_PENDING)) && !wb_hit_s;
        stall         = id_valid && !id_flush && (raw1_s || raw2_s || waw_s || full_s);
        accept_s      = id_valid && !id_flush && !stall && id_reg_we && id_long &&
                        (rd_addr_id != 5'd0);
        set_mask_s    = accept_s ? (32'd1 << rd_addr_id) : 32'd0;
    end

    // Next-state: set wins over clear on the same register; count saturates at both ends.
    always_comb begin
        pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
        cnt_d     = cnt_q;
        ovf_s     = 1'b0;
        case ({accept_s, wb_hit_s})
            2'b10: begin
                if (cnt_q == CNT_W'(MAX_PENDING)) begin
                    ovf_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q || wb_bad_s || ovf_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 32'd0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pending_cnt = cnt_q;
    assign sb_err      = err_q;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Directed bench for long_latency_scoreboard: hazards, full, same-cycle release,
// protocol errors, flush and asynchronous reset.
module tb_long_latency_scoreboard;

    localparam int MAXP = 4;
    localparam int CW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs1_used, rs2_used, id_reg_we, id_long, id_flush, wb_valid;
    logic [4:0]    rs1_addr_id, rs2_addr_id, rd_addr_id, wb_rd_addr;
    logic          stall;
    logic [CW-1:0] pending_cnt;
    logic          sb_err;

    int errors = 0;
    int checks = 0;

    long_latency_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_addr_id(rd_addr_id),
        .id_reg_we(id_reg_we), .id_long(id_long), .id_flush(id_flush),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .stall(stall), .pending_cnt(pending_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an ID instruction: valid, rs1/used, rs2/used, rd, we, long.
    task automatic id(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic lg);
        id_valid = v; rs1_addr_id = r1; rs1_used = u1; rs2_addr_id = r2; rs2_used = u2;
        rd_addr_id = rd; id_reg_we = we; id_long = lg; id_flush = 1'b0;
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        wb_valid = v; wb_rd_addr = a;
    endtask

    task automatic idle();
        id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(1'b0, 5'd0);
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point for combinational stall after inputs settle.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        chk("reset_stall", stall, 0);
        chk("reset_cnt", pending_cnt, 0);
        chk("reset_err", sb_err, 0);
        #9 rst_n = 1'b1;
        tick();

        // Load x5, then add x6,x5,x1 stalls until wb x5 arrives.
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); settle();
        chk("ld5_nostall", stall, 0);
        tick();
        id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); settle();
        chk("raw5_stall", stall, 1);
        chk("raw5_cnt1", pending_cnt, 1);
        tick(); settle();
        chk("raw5_held", stall, 1);
        wb(1'b1, 5'd5); settle();
        chk("raw5_wb_release", stall, 0);
        tick(); idle(); settle();
        chk("raw5_cnt0", pending_cnt, 0);
        chk("raw5_err", sb_err, 0);

        // Fill with x1..x4, load x7 stalls on full, same-cycle wb x2 lets it in.
        for (int r = 1; r <= 4; r++) begin
            id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 1'b1); settle();
            chk("fill_nostall", stall, 0);
            tick();
        end
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); settle();
        chk("full_stall", stall, 1);
        chk("full_cnt4", pending_cnt, 4);
        wb(1'b1, 5'd2); settle();
        chk("full_wb_release", stall, 0);
        tick(); idle();
        id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        chk("full_cnt_stays4", pending_cnt, 4);
        chk("x2_released", stall, 0);
        id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        chk("x7_pending", stall, 1);
        idle();
        wb(1'b1, 5'd1); tick();
        wb(1'b1, 5'd3); tick();
        wb(1'b1, 5'd4); tick();
        wb(1'b1, 5'd7); tick();
        idle(); settle();
        chk("drain_cnt0", pending_cnt, 0);
        chk("drain_err", sb_err, 0);

        // WAW on x9 from a short writer; x0 never hazards or becomes pending.
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1); tick();
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); settle();
        chk("waw9_stall", stall, 1);
        id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); settle();
        chk("x0_nostall", stall, 0);
        tick(); idle(); settle();
        chk("x0_cnt_unchanged", pending_cnt, 1);
        wb(1'b1, 5'd9); tick(); idle(); settle();
        chk("x9_drained", pending_cnt, 0);

        // Pending x3: same-cycle wb x3 and new load x3 keep the bit set.
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
        wb(1'b1, 5'd3); settle();
        chk("same_rd_nostall", stall, 0);
        tick(); idle();
        id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        chk("same_rd_cnt1", pending_cnt, 1);
        chk("same_rd_still_pending", stall, 1);
        idle(); wb(1'b1, 5'd3); tick(); idle(); settle();
        chk("x3_drained", pending_cnt, 0);
        chk("x3_err", sb_err, 0);

        // Writeback of never-issued x12 raises sticky sb_err.
        wb(1'b1, 5'd12); tick(); idle(); settle();
        chk("bad_wb_err", sb_err, 1);
        chk("bad_wb_cnt", pending_cnt, 0);
        tick();
        chk("bad_wb_sticky", sb_err, 1);

        // Flush suppresses stall and accept.
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1); tick();
        id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        id_flush = 1'b1; settle();
        chk("flush_nostall", stall, 0);
        tick(); idle(); settle();
        chk("flush_no_accept", pending_cnt, 1);
        id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        chk("x11_not_pending", stall, 0);
        id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        chk("x10_pending", stall, 1);

        // Three pending, asynchronous reset mid-cycle clears everything.
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1); tick();
        id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1); tick();
        idle(); settle();
        chk("three_pending", pending_cnt, 3);
        rst_n = 1'b0; #1;
        chk("async_rst_cnt", pending_cnt, 0);
        chk("async_rst_err", sb_err, 0);
        #2 rst_n = 1'b1;
        id(1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 1'b0); settle();
        chk("post_rst_nostall", stall, 0);
        idle(); wb(1'b1, 5'd14); tick(); idle(); settle();
        chk("stale_wb_err", sb_err, 1);
        chk("stale_wb_cnt", pending_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/long_latency_scoreboard.md
# long_latency_scoreboard

Tracks destination registers of in-flight long-latency instructions (loads, multi-cycle mul/div) whose results cannot be bypassed from EX, and generates the ID-stage stall for RAW and WAW hazards against them. It is the producer-side counterpart to the EX/WB bypass selection. It sits beside the ID stage: it records a pending write when a long-latency instruction leaves ID, and releases it when that result arrives at writeback.

## Interface
- MAX_PENDING, 4, maximum simultaneously outstanding long-latency writes (1..31)
- CNT_W, $clog2(MAX_PENDING+1), width of pending_cnt
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- rs1_addr_id  in  5  source 1 address of ID instruction
- rs2_addr_id  in  5  source 2 address of ID instruction
- rs1_used, rs2_used  in  1 each  ID instruction actually reads rs1 / rs2
- rd_addr_id  in  5  destination address of ID instruction
- id_reg_we  in  1  ID instruction writes rd
- id_long  in  1  ID instruction is long-latency (result not forwardable from EX)
- id_flush  in  1  ID instruction is being killed this cycle (branch redirect)
- wb_valid  in  1  a long-latency result is written back this cycle
- wb_rd_addr  in  5  destination of that result
- stall  out  1  hold ID/IF this cycle (combinational)
- pending_cnt  out  CNT_W  number of outstanding long-latency writes (registered)
- sb_err  out  1  sticky protocol-violation flag (registered)

## Operation
- State: pending[31:1] bits (x0 never pending), pending_cnt, sb_err.
- wb_hit = wb_valid && wb_rd_addr != 0 && pending[wb_rd_addr].
- eff_pending[r] = pending[r] && !(wb_hit && wb_rd_addr == r). A same-cycle writeback releases the hazard through the WB bypass path.
- raw1 = rs1_used && rs1_addr_id != 0 && eff_pending[rs1_addr_id]. raw2 is the same for rs2.
- waw = id_reg_we && rd_addr_id != 0 && eff_pending[rd_addr_id]. This covers short and long writers, which keeps at most one pending write per register.
- full = id_long && id_reg_we && rd_addr_id != 0 && pending_cnt == MAX_PENDING && !wb_hit.
- stall = id_valid && !id_flush && (raw1 || raw2 || waw || full).
- accept = id_valid && !id_flush && !stall && id_reg_we && id_long && rd_addr_id != 0.
- Next state:
  - pending[rd] is set on accept.
  - pending[wb_rd] is cleared on wb_hit.
  - Set wins when both target the same register in the same cycle.
- pending_cnt next = pending_cnt + accept - wb_hit. It never exceeds MAX_PENDING or goes below 0.
- sb_err sets and holds until reset when:
  - wb_valid && wb_rd_addr != 0 && !pending[wb_rd_addr] (writeback of a non-pending register), or
  - the count would overflow.
  - Non-pending writebacks are otherwise ignored.
- Short-latency writers never set pending; their hazards are handled by bypass.

## Timing
- Reset (rst_n low, asynchronous): pending = 0, pending_cnt = 0, sb_err = 0. stall is therefore 0 during and immediately after reset.
- stall is combinational from the current-cycle inputs and registered state. It has no latency, and the ID instruction re-evaluates every cycle it is held.
- Accepted long op in cycle N: pending bit and count are visible in cycle N+1. A dependent instruction in ID at N+1 stalls.
- Writeback in cycle M: the dependent instruction is released in cycle M (stall low), and the bit is clear from M+1.
- Simultaneous accept and wb_hit on the same rd: issue is allowed, the bit stays set, and the count is unchanged.
- Full with a same-cycle wb_hit: the new op is accepted and the count is unchanged.
- id_flush suppresses both stall and accept. Already-pending entries are never cancelled; in-flight long ops always write back.
- rst_n asserted mid-operation clears all state immediately. Later writebacks for pre-reset entries raise sb_err.

## Test plan
- Load x5 accepted at N, then `add x6,x5,x1` in ID at N+1 with no wb → stall=1 until the cycle wb_valid/wb_rd_addr=5 arrives, stall=0 that cycle; pending_cnt 1→0 the cycle after.
- MAX_PENDING=4: loads to x1..x4 accepted, load to x7 in ID → stall=1 (full). Assert wb of x2 in the same cycle → stall=0, x7 accepted, pending_cnt stays 4.
- Pending x9, ID instruction writes x9 (short, id_long=0) → stall=1 (WAW). Also: rs1=x0 with an ID instruction writing x0 → stall=0 and pending unchanged.
- Pending x3, same cycle: wb x3 and accept new load to x3 → stall=0, pending[3] remains 1, pending_cnt unchanged.
- wb_valid with wb_rd_addr=12 never issued → sb_err=1 next cycle and sticky, pending_cnt unchanged. Then assert id_flush with a RAW on pending reg → stall=0 and no accept.
- Three loads pending, pull rst_n low between edges → pending_cnt=0 and sb_err=0 immediately; a following RAW on those regs gives stall=0.
